// File: rtl/vx_ifetch_stage.sv
// ---------------------------------------------------------------------------
// vx_ifetch_stage
// Instruction-fetch stage sitting directly behind the warp scheduler.
// A scheduled fetch (wid, PC, tmask) becomes a word-aligned instruction-cache
// read tagged with the warp id. The warp's {tmask, PC} are parked until the
// cache answers. The answer then leaves through one registered output stage
// towards decode.
//
// Ports
//   clk, reset          core clock, synchronous active-high reset
//   ifetch_req_*        request from scheduler (valid/ready, wid, PC, tmask)
//   icache_req_*        read to icache (valid/ready, word addr, warp tag)
//   icache_rsp_*        icache answer (valid/ready, data, warp tag)
//   ifetch_rsp_*        registered response to decode (valid/ready, wid, PC,
//                       tmask, instr)
//   busy                any fetch pending or a response still held
// ---------------------------------------------------------------------------
module vx_ifetch_stage #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 4,
    parameter int NW_BITS     = $clog2(NUM_WARPS)
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   ifetch_req_valid,
    output logic                   ifetch_req_ready,
    input  logic [NW_BITS-1:0]     ifetch_req_wid,
    input  logic [31:0]            ifetch_req_PC,
    input  logic [NUM_THREADS-1:0] ifetch_req_tmask,

    output logic                   icache_req_valid,
    input  logic                   icache_req_ready,
    output logic [29:0]            icache_req_addr,
    output logic [NW_BITS-1:0]     icache_req_tag,

    input  logic                   icache_rsp_valid,
    output logic                   icache_rsp_ready,
    input  logic [31:0]            icache_rsp_data,
    input  logic [NW_BITS-1:0]     icache_rsp_tag,

    output logic                   ifetch_rsp_valid,
    input  logic                   ifetch_rsp_ready,
    output logic [NW_BITS-1:0]     ifetch_rsp_wid,
    output logic [31:0]            ifetch_rsp_PC,
    output logic [NUM_THREADS-1:0] ifetch_rsp_tmask,
    output logic [31:0]            ifetch_rsp_instr,

    output logic                   busy
);

    logic [NUM_WARPS-1:0]   pending_q;
    logic [NUM_WARPS-1:0]   pending_d;
    logic [31:0]            meta_pc_q    [NUM_WARPS];
    logic [NUM_THREADS-1:0] meta_tmask_q [NUM_WARPS];

    logic                   out_valid_q;
    logic [NW_BITS-1:0]     out_wid_q;
    logic [31:0]            out_pc_q;
    logic [NUM_THREADS-1:0] out_tmask_q;
    logic [31:0]            out_instr_q;

    logic req_blocked_s;
    logic req_fire_s;
    logic stall_s;
    logic rsp_fire_s;
    logic rsp_hit_s;

    // A warp with a fetch already outstanding is held back until its answer.
    assign req_blocked_s    = pending_q[ifetch_req_wid];
    assign icache_req_valid = ifetch_req_valid & ~req_blocked_s;
    assign ifetch_req_ready = icache_req_ready & ~req_blocked_s;
    assign icache_req_addr  = ifetch_req_PC[31:2];
    assign icache_req_tag   = ifetch_req_wid;
    assign req_fire_s       = icache_req_valid & icache_req_ready;

    assign stall_s          = out_valid_q & ~ifetch_rsp_ready;
    assign icache_rsp_ready = ~stall_s;
    assign rsp_fire_s       = icache_rsp_valid & icache_rsp_ready;
    // A response for a warp that is not pending (orphan) is swallowed.
    assign rsp_hit_s        = rsp_fire_s & pending_q[icache_rsp_tag];

    assign ifetch_rsp_valid = out_valid_q;
    assign ifetch_rsp_wid   = out_wid_q;
    assign ifetch_rsp_PC    = out_pc_q;
    assign ifetch_rsp_tmask = out_tmask_q;
    assign ifetch_rsp_instr = out_instr_q;
    assign busy             = (|pending_q) | out_valid_q;

    // Pending next state: clear on answer first, then set on new request so an
    // orphan for warp w cannot cancel a fresh request from warp w.
    always_comb begin
        pending_d = pending_q;
        if (rsp_fire_s) begin
            pending_d[icache_rsp_tag] = 1'b0;
        end else begin
            pending_d = pending_q;
        end
        if (req_fire_s) begin
            pending_d[ifetch_req_wid] = 1'b1;
        end else begin
            pending_d = pending_d;
        end
    end

    // Pending-warp register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= {NUM_WARPS{1'b0}};
        end else begin
            pending_q <= pending_d;
        end
    end

    // Per-warp metadata capture; contents are don't-care while not pending.
    always_ff @(posedge clk) begin
        if (req_fire_s) begin
            meta_pc_q[ifetch_req_wid]    <= ifetch_req_PC;
            meta_tmask_q[ifetch_req_wid] <= ifetch_req_tmask;
        end
    end

    // Output stage valid bit; held while decode stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
        end else if (!stall_s) begin
            out_valid_q <= rsp_hit_s;
        end
    end

    // Output stage payload; meta is read before any same-cycle write.
    always_ff @(posedge clk) begin
        if (!stall_s && rsp_hit_s) begin
            out_wid_q   <= icache_rsp_tag;
            out_pc_q    <= meta_pc_q[icache_rsp_tag];
            out_tmask_q <= meta_tmask_q[icache_rsp_tag];
            out_instr_q <= icache_rsp_data;
        end
    end

    vx_ifetch_stage_chk u_chk (
        .clk        (clk),
        .reset      (reset),
        .rsp_fire_i (rsp_fire_s),
        .rsp_hit_i  (rsp_hit_s)
    );

endmodule

// ---------------------------------------------------------------------------
// vx_ifetch_stage_chk
// Simulation-only observer: reports orphan cache responses as a warning,
// since they are legal after a reset cut in-flight fetches.
//   clk, reset   core clock and reset
//   rsp_fire_i   cache response accepted
//   rsp_hit_i    accepted response matched a pending warp
// ---------------------------------------------------------------------------
module vx_ifetch_stage_chk (
    input logic clk,
    input logic reset,
    input logic rsp_fire_i,
    input logic rsp_hit_i
);

    // Flag responses that arrive for a warp with nothing outstanding.
    always @(posedge clk) begin
        if (!reset && rsp_fire_i && !rsp_hit_i) begin
            $warning("vx_ifetch_stage: orphan icache response discarded");
        end
    end

endmodule

// File: tb/tb_vx_ifetch_stage.sv
module tb_vx_ifetch_stage;

    localparam int NW = 4;
    localparam int NT = 4;
    localparam int NB = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          ifetch_req_valid, ifetch_req_ready;
    logic [NB-1:0] ifetch_req_wid;
    logic [31:0]   ifetch_req_PC;
    logic [NT-1:0] ifetch_req_tmask;
    logic          icache_req_valid, icache_req_ready;
    logic [29:0]   icache_req_addr;
    logic [NB-1:0] icache_req_tag;
    logic          icache_rsp_valid, icache_rsp_ready;
    logic [31:0]   icache_rsp_data;
    logic [NB-1:0] icache_rsp_tag;
    logic          ifetch_rsp_valid, ifetch_rsp_ready;
    logic [NB-1:0] ifetch_rsp_wid;
    logic [31:0]   ifetch_rsp_PC;
    logic [NT-1:0] ifetch_rsp_tmask;
    logic [31:0]   ifetch_rsp_instr;
    logic          busy;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    vx_ifetch_stage #(.NUM_WARPS(NW), .NUM_THREADS(NT)) dut (
        .clk(clk), .reset(reset),
        .ifetch_req_valid(ifetch_req_valid), .ifetch_req_ready(ifetch_req_ready),
        .ifetch_req_wid(ifetch_req_wid), .ifetch_req_PC(ifetch_req_PC),
        .ifetch_req_tmask(ifetch_req_tmask),
        .icache_req_valid(icache_req_valid), .icache_req_ready(icache_req_ready),
        .icache_req_addr(icache_req_addr), .icache_req_tag(icache_req_tag),
        .icache_rsp_valid(icache_rsp_valid), .icache_rsp_ready(icache_rsp_ready),
        .icache_rsp_data(icache_rsp_data), .icache_rsp_tag(icache_rsp_tag),
        .ifetch_rsp_valid(ifetch_rsp_valid), .ifetch_rsp_ready(ifetch_rsp_ready),
        .ifetch_rsp_wid(ifetch_rsp_wid), .ifetch_rsp_PC(ifetch_rsp_PC),
        .ifetch_rsp_tmask(ifetch_rsp_tmask), .ifetch_rsp_instr(ifetch_rsp_instr),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Outstanding set of warps with their parked request, plus the one slot
    // that is currently presented to decode.
    bit            m_pend [NW];
    logic [31:0]   m_pc   [NW];
    logic [NT-1:0] m_tm   [NW];
    bit            m_v;
    logic [NB-1:0] m_wid;
    logic [31:0]   m_opc;
    logic [NT-1:0] m_otm;
    logic [31:0]   m_ins;

    wire m_stall    = m_v && !ifetch_rsp_ready;
    wire m_take_rsp = icache_rsp_valid && !m_stall;
    wire m_take_req = ifetch_req_valid && icache_req_ready && !m_pend[ifetch_req_wid];
    wire m_any_pend = m_pend[0] || m_pend[1] || m_pend[2] || m_pend[3];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NW; i++) m_pend[i] <= 1'b0;
            m_v <= 1'b0;
        end else begin
            for (int i = 0; i < NW; i++) begin
                if (m_take_req && int'(ifetch_req_wid) == i) m_pend[i] <= 1'b1;
                else if (m_take_rsp && int'(icache_rsp_tag) == i) m_pend[i] <= 1'b0;
            end
            if (m_take_req) begin
                m_pc[ifetch_req_wid] <= ifetch_req_PC;
                m_tm[ifetch_req_wid] <= ifetch_req_tmask;
            end
            if (!m_stall) begin
                m_v <= m_take_rsp && m_pend[icache_rsp_tag];
                if (m_take_rsp && m_pend[icache_rsp_tag]) begin
                    m_wid <= icache_rsp_tag;
                    m_opc <= m_pc[icache_rsp_tag];
                    m_otm <= m_tm[icache_rsp_tag];
                    m_ins <= icache_rsp_data;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_req_ready", 64'(ifetch_req_ready), 64'(icache_req_ready && !m_pend[ifetch_req_wid]));
            chk("m_icreq_valid", 64'(icache_req_valid), 64'(ifetch_req_valid && !m_pend[ifetch_req_wid]));
            if (ifetch_req_valid) begin
                chk("m_icreq_addr", 64'(icache_req_addr), 64'(ifetch_req_PC >> 2));
                chk("m_icreq_tag", 64'(icache_req_tag), 64'(ifetch_req_wid));
            end
            chk("m_icrsp_ready", 64'(icache_rsp_ready), 64'(!m_stall));
            chk("m_busy", 64'(busy), 64'(m_any_pend || m_v));
            chk("m_out_valid", 64'(ifetch_rsp_valid), 64'(m_v));
            if (m_v) begin
                chk("m_out_wid", 64'(ifetch_rsp_wid), 64'(m_wid));
                chk("m_out_pc", 64'(ifetch_rsp_PC), 64'(m_opc));
                chk("m_out_tmask", 64'(ifetch_rsp_tmask), 64'(m_otm));
                chk("m_out_instr", 64'(ifetch_rsp_instr), 64'(m_ins));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic v, input logic [NB-1:0] w, input logic [31:0] pc, input logic [NT-1:0] tm);
        ifetch_req_valid = v;
        ifetch_req_wid   = w;
        ifetch_req_PC    = pc;
        ifetch_req_tmask = tm;
    endtask

    task automatic rsp(input logic v, input logic [NB-1:0] t, input logic [31:0] d);
        icache_rsp_valid = v;
        icache_rsp_tag   = t;
        icache_rsp_data  = d;
    endtask

    task automatic out_is(input string n, input logic [NB-1:0] w, input logic [31:0] pc,
                          input logic [NT-1:0] tm, input logic [31:0] ins);
        chk({n, "_valid"}, 64'(ifetch_rsp_valid), 64'd1);
        chk({n, "_wid"},   64'(ifetch_rsp_wid),   64'(w));
        chk({n, "_pc"},    64'(ifetch_rsp_PC),    64'(pc));
        chk({n, "_tmask"}, 64'(ifetch_rsp_tmask), 64'(tm));
        chk({n, "_instr"}, 64'(ifetch_rsp_instr), 64'(ins));
    endtask

    initial begin
        reset = 1'b1;
        req(1'b0, 2'd0, 32'h0, 4'h0);
        rsp(1'b0, 2'd0, 32'h0);
        icache_req_ready = 1'b1;
        ifetch_rsp_ready = 1'b1;
        step(); step();
        reset = 1'b0;
        chk_en = 1'b1;
        chk("rst_valid", 64'(ifetch_rsp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_icrsp_ready", 64'(icache_rsp_ready), 64'd1);

        // Single fetch
        req(1'b1, 2'd0, 32'h8000_0000, 4'b0001);
        #1;
        chk("t1_addr", 64'(icache_req_addr), 64'h2000_0000);
        chk("t1_req_ready", 64'(ifetch_req_ready), 64'd1);
        step();
        req(1'b0, 2'd0, 32'h0, 4'h0);
        step();
        rsp(1'b1, 2'd0, 32'h0000_0513);
        step();
        rsp(1'b0, 2'd0, 32'h0);
        out_is("t1_out", 2'd0, 32'h8000_0000, 4'b0001, 32'h0000_0513);
        step();
        chk("t1_busy_after", 64'(busy), 64'd0);

        // Per-warp block
        req(1'b1, 2'd1, 32'h0000_0100, 4'b0010);
        step();
        req(1'b1, 2'd1, 32'h0000_0104, 4'b0100);
        #1;
        chk("t2_blocked0", 64'(ifetch_req_ready), 64'd0);
        step();
        chk("t2_blocked1", 64'(ifetch_req_ready), 64'd0);
        rsp(1'b1, 2'd1, 32'hAAAA_0001);
        #1;
        chk("t2_blocked_rspcyc", 64'(ifetch_req_ready), 64'd0);
        step();
        rsp(1'b0, 2'd0, 32'h0);
        chk("t2_accept", 64'(ifetch_req_ready), 64'd1);
        out_is("t2_out_a", 2'd1, 32'h0000_0100, 4'b0010, 32'hAAAA_0001);
        step();
        req(1'b0, 2'd0, 32'h0, 4'h0);
        rsp(1'b1, 2'd1, 32'hAAAA_0002);
        step();
        rsp(1'b0, 2'd0, 32'h0);
        out_is("t2_out_b", 2'd1, 32'h0000_0104, 4'b0100, 32'hAAAA_0002);
        step();

        // Out-of-order
        req(1'b1, 2'd2, 32'h0000_0200, 4'b1111);
        step();
        req(1'b1, 2'd3, 32'h0000_0300, 4'b0011);
        step();
        req(1'b0, 2'd0, 32'h0, 4'h0);
        rsp(1'b1, 2'd3, 32'h3333_3333);
        step();
        out_is("t3_first", 2'd3, 32'h0000_0300, 4'b0011, 32'h3333_3333);
        rsp(1'b1, 2'd2, 32'h2222_2222);
        step();
        rsp(1'b0, 2'd0, 32'h0);
        out_is("t3_second", 2'd2, 32'h0000_0200, 4'b1111, 32'h2222_2222);
        step();

        // Backpressure
        req(1'b1, 2'd0, 32'h0000_0400, 4'b0110);
        step();
        req(1'b1, 2'd1, 32'h0000_0501, 4'b1001);
        step();
        req(1'b0, 2'd0, 32'h0, 4'h0);
        ifetch_rsp_ready = 1'b0;
        rsp(1'b1, 2'd0, 32'h0000_00D0);
        step();
        rsp(1'b1, 2'd1, 32'h0000_00D1);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t4_icrsp_ready", 64'(icache_rsp_ready), 64'd0);
            out_is("t4_hold", 2'd0, 32'h0000_0400, 4'b0110, 32'h0000_00D0);
            step();
        end
        ifetch_rsp_ready = 1'b1;
        #1;
        chk("t4_release", 64'(icache_rsp_ready), 64'd1);
        step();
        rsp(1'b0, 2'd0, 32'h0);
        out_is("t4_second", 2'd1, 32'h0000_0501, 4'b1001, 32'h0000_00D1);
        step();

        // Reset mid-flight
        req(1'b1, 2'd0, 32'h0000_0600, 4'b0001);
        step();
        req(1'b0, 2'd0, 32'h0, 4'h0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_busy_rst", 64'(busy), 64'd0);
        rsp(1'b1, 2'd0, 32'h0000_0BAD);
        #1;
        chk("t5_icrsp_ready", 64'(icache_rsp_ready), 64'd1);
        step();
        rsp(1'b0, 2'd0, 32'h0);
        chk("t5_no_out", 64'(ifetch_rsp_valid), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        step();

        // Same-cycle response and request on different warps
        req(1'b1, 2'd1, 32'h0000_0700, 4'b1010);
        step();
        req(1'b1, 2'd2, 32'h0000_0800, 4'b0101);
        rsp(1'b1, 2'd1, 32'h0000_0071);
        #1;
        chk("t6_req_ready", 64'(ifetch_req_ready), 64'd1);
        step();
        req(1'b0, 2'd0, 32'h0, 4'h0);
        rsp(1'b0, 2'd0, 32'h0);
        out_is("t6_out", 2'd1, 32'h0000_0700, 4'b1010, 32'h0000_0071);
        chk("t6_busy", 64'(busy), 64'd1);
        req(1'b1, 2'd2, 32'h0000_0900, 4'b0001);
        #1;
        chk("t6_w2_pending", 64'(ifetch_req_ready), 64'd0);
        req(1'b0, 2'd0, 32'h0, 4'h0);
        rsp(1'b1, 2'd2, 32'h0000_0082);
        step();
        rsp(1'b0, 2'd0, 32'h0);
        out_is("t6_drain", 2'd2, 32'h0000_0800, 4'b0101, 32'h0000_0082);
        step();
        step();
        chk("end_busy", 64'(busy), 64'd0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vx_ifetch_stage.md
Name: vx_ifetch_stage

Overview:
Instruction-fetch stage directly downstream of the warp scheduler. It accepts scheduled fetch requests (wid, PC, thread mask), issues word-aligned reads to the instruction cache tagged by warp id, and parks per-warp metadata until the cache answers. It then emits a registered fetch response (wid, PC, tmask, instruction) to decode; that response's fire is what releases the scheduler's per-warp fetch lock.

Parameters:
NUM_WARPS, 4, warps per core (power of two, >=2)
NUM_THREADS, 4, threads per warp (tmask width)
NW_BITS, log2(NUM_WARPS), warp-id / cache-tag width

Ports:
clk  input  1  core clock
reset  input  1  reset; synchronous, active-high
ifetch_req_valid  input  1  scheduled fetch request valid
ifetch_req_ready  output  1  request accepted this cycle
ifetch_req_wid  input  NW_BITS  warp id
ifetch_req_PC  input  32  fetch PC
ifetch_req_tmask  input  NUM_THREADS  thread mask
icache_req_valid  output  1  cache read valid
icache_req_ready  input  1  cache can accept
icache_req_addr  output  30  word address = PC[31:2]
icache_req_tag  output  NW_BITS  = ifetch_req_wid
icache_rsp_valid  input  1  cache data valid
icache_rsp_ready  output  1  stage can take cache data
icache_rsp_data  input  32  instruction word
icache_rsp_tag  input  NW_BITS  returning warp id
ifetch_rsp_valid  output  1  fetch response valid
ifetch_rsp_ready  input  1  decode accepts
ifetch_rsp_wid  output  NW_BITS  warp id
ifetch_rsp_PC  output  32  original PC, unmodified
ifetch_rsp_tmask  output  NUM_THREADS  thread mask captured at request
ifetch_rsp_instr  output  32  instruction
busy  output  1  fetch in flight

Behaviour:
- State: pending[NUM_WARPS] bit vector; meta[NUM_WARPS] = {tmask, PC} regs; one output pipe register {valid, wid, PC, tmask, instr}.
- Request path, combinational, 0 latency: icache_req_valid = ifetch_req_valid & ~pending[wid]; ifetch_req_ready = icache_req_ready & ~pending[wid]; addr = PC[31:2]; tag = wid. PC[1:0] is ignored for addressing but forwarded unchanged.
- req_fire (icache_req_valid & icache_req_ready): at the next edge meta[wid] <= {tmask, PC} and pending[wid] <= 1.
- At most one outstanding fetch per warp. A second request for a pending warp is held (ready=0) and never dropped.
- stall = ifetch_rsp_valid & ~ifetch_rsp_ready. icache_rsp_ready = ~stall.
- rsp_fire = icache_rsp_valid & icache_rsp_ready:
  - pending[tag] <= 0.
  - If pending[tag] was 1: the pipe register loads {1, tag, meta[tag].PC, meta[tag].tmask, data}.
  - If pending[tag] was 0 (orphan, e.g. a response arriving after reset): the data is consumed and discarded, no output is produced, and the pipe loads valid=0 if it was not stalled.
- Output pipe: enable = ~stall. When enabled and there is no valid rsp_fire, it loads valid=0. Latency is icache_rsp fire -> ifetch_rsp_valid = 1 cycle. Outputs hold stable while stalled.
- Same-cycle events:
  - rsp_fire for warp w plus ifetch_req for warp w: the request is blocked that cycle (registered pending). It is accepted at the earliest next cycle.
  - rsp_fire for warp w plus req_fire for warp v≠w: both proceed.
  - Meta is read before write. Since w is pending it cannot be written in the same cycle.
- Responses may return out of order across warps. Order is preserved per warp trivially.
- busy = (|pending) | ifetch_rsp_valid.
- Reset (any time, including mid-operation): pending=0, ifetch_rsp_valid=0, busy=0, ifetch_req_ready follows icache_req_ready, icache_req_valid follows ifetch_req_valid, icache_rsp_ready=1. Meta contents and the pipe data fields are don't-care. In-flight cache responses are later discarded as orphans.
- Simulation assertion: an orphan response fires a warning, not an error (it is legal after reset).

Test Plan:
- Single fetch: req wid=0, PC=0x80000000, tmask=4'b0001, cache ready; rsp tag=0, data=0x00000513 two cycles later -> icache_req_addr=0x20000000; one cycle after the rsp, ifetch_rsp_valid=1 with wid=0, PC=0x80000000, tmask=0001, instr=0x00000513; busy=0 after the rsp fire.
- Per-warp block: req wid=1 accepted, then a second req wid=1 PC=0x104 -> ifetch_req_ready=0 until the rsp for tag 1 fires; accepted exactly one cycle after that fire.
- Out-of-order: reqs wid=2 (PC 0x200, tmask 1111) then wid=3 (PC 0x300, tmask 0011); rsps return tag 3 then tag 2 -> outputs appear in that order, each with its own PC/tmask.
- Backpressure: ifetch_rsp_ready=0 for 3 cycles with an output valid and a second cache rsp pending -> icache_rsp_ready=0 for those 3 cycles, outputs are stable, no loss; both delivered after ready=1.
- Reset mid-flight: req wid=0 issued, reset pulsed one cycle, then cache returns tag 0 -> rsp consumed with icache_rsp_ready=1, ifetch_rsp_valid stays 0, busy=0.
- Same-cycle: rsp tag=1 fires while req wid=2 fires -> pending becomes {2}, and the output carries the wid=1 data next cycle.
